// File: rtl/constant_sink_checker.sv
// constant_sink_checker
//   Consumer-side self-test checker for a constant-generator block. After a
//   start pulse it samples sample_data on every cycle that sample_valid is
//   high, and compares each sample against EXPECTED. It declares PASS after
//   REQUIRED consecutive matching samples. It declares FAIL on the first
//   mismatch, or after TIMEOUT consecutive cycles with no valid sample.
//
// Ports
//   CLK            system clock, rising edge
//   RESET_N        asynchronous active-low reset
//   start          one-cycle pulse that begins a check run (ignored while busy)
//   sample_valid   sample_data is meaningful this cycle
//   sample_data    value from the constant source
//   busy           run in progress
//   done           verdict reached (pass or fail)
//   pass           run passed
//   fail           run failed
//   timeout        failure was caused by a stall timeout
//   match_count    matching samples in the current run
//   mismatch_count mismatching samples in the current run (0 or 1)
//   first_bad      value of the first mismatching sample
module constant_sink_checker #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned EXPECTED = 12,
  parameter int unsigned REQUIRED = 8,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] mismatch_count,
  output logic [WIDTH-1:0] first_bad
);

  localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

  localparam logic [WIDTH-1:0]   EXP_V = WIDTH'(EXPECTED);
  localparam logic [CNT_W-1:0]   REQ_V = CNT_W'(REQUIRED);
  localparam logic [STALL_W-1:0] TO_V  = STALL_W'(TIMEOUT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_PASS  = 2'd2;
  localparam logic [1:0] ST_FAIL  = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   match_q, match_d;
  logic [CNT_W-1:0]   mism_q, mism_d;
  logic [WIDTH-1:0]   first_bad_q, first_bad_d;
  logic               timeout_q, timeout_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  always_comb begin
    state_d     = state_q;
    match_d     = match_q;
    mism_d      = mism_q;
    first_bad_d = first_bad_q;
    timeout_d   = timeout_q;
    stall_d     = stall_q;

    case (state_q)
      ST_CHECK: begin
        if (sample_valid) begin
          // Case equality so that any X/Z bit in the sample is a mismatch.
          if (sample_data === EXP_V) begin
            stall_d = '0;
            if (match_q != {CNT_W{1'b1}}) begin
              match_d = match_q + CNT_W'(1);
            end
            if (match_d == REQ_V) begin
              state_d = ST_PASS;
            end
          end else begin
            mism_d      = CNT_W'(1);
            first_bad_d = sample_data;
            state_d     = ST_FAIL;
          end
        end else begin
          stall_d = stall_q + STALL_W'(1);
          if (stall_d == TO_V) begin
            timeout_d = 1'b1;
            state_d   = ST_FAIL;
          end
        end
      end
      default: begin
        // IDLE, PASS and FAIL all restart the same way; a start pulse
        // clears every run register.
        if (start) begin
          state_d     = ST_CHECK;
          match_d     = '0;
          mism_d      = '0;
          first_bad_d = '0;
          timeout_d   = 1'b0;
          stall_d     = '0;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      match_q     <= '0;
      mism_q      <= '0;
      first_bad_q <= '0;
      timeout_q   <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      match_q     <= match_d;
      mism_q      <= mism_d;
      first_bad_q <= first_bad_d;
      timeout_q   <= timeout_d;
      stall_q     <= stall_d;
    end
  end

  assign busy           = (state_q == ST_CHECK);
  assign done           = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign pass           = (state_q == ST_PASS);
  assign fail           = (state_q == ST_FAIL);
  assign timeout        = timeout_q;
  assign match_count    = match_q;
  assign mismatch_count = mism_q;
  assign first_bad      = first_bad_q;

endmodule

// File: tb/tb_constant_sink_checker.sv
// Directed self-checking bench for constant_sink_checker.
// Each run pushes its expected verdict to a scoreboard queue when its stimulus
// is driven. The verdict is popped and compared once the DUT raises done.
module tb_constant_sink_checker;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       start = 1'b0;
  logic       sample_valid = 1'b0;
  logic [3:0] sample_data = 4'd0;
  logic       busy, done, pass, fail, timeout;
  logic [7:0] match_count, mismatch_count;
  logic [3:0] first_bad;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string      tag;
    logic       pass;
    logic       timeout;
    logic [7:0] match;
    logic [7:0] mism;
    logic [3:0] first_bad;
  } verdict_t;

  verdict_t sb[$];

  constant_sink_checker dut (
    .CLK            (CLK),
    .RESET_N        (RESET_N),
    .start          (start),
    .sample_valid   (sample_valid),
    .sample_data    (sample_data),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail           (fail),
    .timeout        (timeout),
    .match_count    (match_count),
    .mismatch_count (mismatch_count),
    .first_bad      (first_bad)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [3:0] d);
    sample_valid = v;
    sample_data  = d;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic push(input string tag, input logic p, input logic t, input logic [7:0] m,
                      input logic [7:0] mm, input logic [3:0] fb);
    verdict_t v;
    v.tag = tag; v.pass = p; v.timeout = t; v.match = m; v.mism = mm; v.first_bad = fb;
    sb.push_back(v);
  endtask

  // Pop the oldest expected verdict and compare it against the DUT once done.
  task automatic expect_verdict(input int budget);
    verdict_t v;
    int n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    v = sb.pop_front();
    chk({v.tag, "_done"}, 32'(done), 32'd1);
    chk({v.tag, "_pass"}, 32'(pass), 32'(v.pass));
    chk({v.tag, "_fail"}, 32'(fail), 32'(!v.pass));
    chk({v.tag, "_busy"}, 32'(busy), 32'd0);
    chk({v.tag, "_timeout"}, 32'(timeout), 32'(v.timeout));
    chk({v.tag, "_match"}, 32'(match_count), 32'(v.match));
    chk({v.tag, "_mism"}, 32'(mismatch_count), 32'(v.mism));
    chk({v.tag, "_first_bad"}, 32'(first_bad), 32'(v.first_bad));
  endtask

  initial begin
    // Reset state.
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_match", 32'(match_count), 32'd0);
    RESET_N = 1'b1;
    step();
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Eight matching samples: pass one cycle after the 8th sample.
    push("pass8", 1'b1, 1'b0, 8'd8, 8'd0, 4'd0);
    pulse_start();
    chk("start_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 7; i++) drive(1'b1, 4'd12);
    chk("pass8_pre_done", 32'(done), 32'd0);
    drive(1'b1, 4'd12);
    chk("pass8_edge_pass", 32'(pass), 32'd1);
    expect_verdict(4);

    // Mismatch after three matches; later samples change nothing.
    push("mism", 1'b0, 1'b0, 8'd3, 8'd1, 4'd13);
    pulse_start();
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd12);
    drive(1'b1, 4'd13);
    chk("mism_edge_fail", 32'(fail), 32'd1);
    drive(1'b1, 4'd12);
    drive(1'b1, 4'd7);
    expect_verdict(4);

    // Stall timeout after two matches.
    push("tmo", 1'b0, 1'b1, 8'd2, 8'd0, 4'd0);
    pulse_start();
    for (int i = 0; i < 2; i++) drive(1'b1, 4'd12);
    for (int i = 0; i < 15; i++) drive(1'b0, 4'd12);
    chk("tmo_15_busy", 32'(busy), 32'd1);
    drive(1'b0, 4'd12);
    expect_verdict(4);

    // Gaps of 15 idle cycles between matches never time out.
    push("gaps", 1'b1, 1'b0, 8'd8, 8'd0, 4'd0);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < 15; g++) drive(1'b0, 4'd0);
      drive(1'b1, 4'd12);
    end
    expect_verdict(4);

    // Start coincident with a valid sample: that sample is not counted.
    sample_valid = 1'b1;
    sample_data  = 4'd12;
    pulse_start();
    chk("coinc_match", 32'(match_count), 32'd0);
    chk("coinc_busy", 32'(busy), 32'd1);
    drive(1'b1, 4'd12);
    // Start during CHECK is ignored; the cycle is an idle stall.
    push("restart", 1'b0, 1'b0, 8'd2, 8'd1, 4'd3);
    pulse_start();
    chk("chk_start_busy", 32'(busy), 32'd1);
    chk("chk_start_match", 32'(match_count), 32'd1);
    drive(1'b1, 4'd12);
    drive(1'b1, 4'd3);
    expect_verdict(4);

    // Start from FAIL clears counters and first_bad.
    pulse_start();
    chk("refail_busy", 32'(busy), 32'd1);
    chk("refail_first_bad", 32'(first_bad), 32'd0);
    chk("refail_match", 32'(match_count), 32'd0);
    chk("refail_mism", 32'(mismatch_count), 32'd0);

    // Asynchronous reset mid-CHECK.
    drive(1'b1, 4'd12);
    drive(1'b1, 4'd12);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_match", 32'(match_count), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    step();
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 4'd12);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_match", 32'(match_count), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/constant_sink_checker.md
Name: constant_sink_checker

Overview:
- Consumer-side checker for the datapath's constant-generator blocks (e.g. the 4-bit constant-12 source).
- Samples a constant bus under a valid strobe and compares each sample against an expected value.
- Declares PASS after a required run of matching samples; declares FAIL on the first mismatch or on a stall timeout.
- Sits beside any constant source in datapath self-test, so hardware gives the pass/fail verdict instead of a bench printout.

Parameters:
WIDTH, 4, width of the sampled constant bus
EXPECTED, 12, value every sample must equal
REQUIRED, 8, number of matching valid samples needed for PASS (1..2^CNT_W-1)
TIMEOUT, 16, consecutive CHECK cycles without sample_valid that force FAIL (>=1)
CNT_W, 8, width of the match/mismatch counters

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse that begins a check run
sample_valid  input  1  sample_data is meaningful this cycle
sample_data  input  WIDTH  value from the constant source
busy  output  1  high while in CHECK
done  output  1  high in PASS or FAIL
pass  output  1  high in PASS
fail  output  1  high in FAIL
timeout  output  1  FAIL was caused by a stall timeout
match_count  output  CNT_W  matching samples in the current run
mismatch_count  output  CNT_W  mismatching samples in the current run (0 or 1)
first_bad  output  WIDTH  value of the first mismatching sample

Behaviour:
- Reset (RESET_N low, asynchronous): state=IDLE; busy, done, pass, fail, timeout = 0; counters, first_bad and the stall counter = 0.
  - Reset release is synchronous to CLK.
  - Reset during CHECK aborts the run with no verdict.
- All outputs are registered and driven directly from state/registers.
- States: IDLE, CHECK, PASS, FAIL.
- IDLE:
  - start=1 → CHECK on the next edge.
  - That edge clears match_count, mismatch_count, first_bad, timeout and the stall counter.
  - sample_valid in the same cycle as start is ignored; counting begins the cycle after the start edge.
- CHECK (busy=1), evaluated on each edge:
  - sample_valid=1 and sample_data==EXPECTED: match_count+1, stall counter cleared.
    - If the new match_count==REQUIRED → PASS on that same edge; pass is visible one cycle after the final valid sample.
  - sample_valid=1 and sample_data!=EXPECTED: mismatch_count=1, first_bad=sample_data → FAIL on that edge.
    - Any X/Z bit counts as a mismatch; the comparison uses case equality.
  - sample_valid=0: stall counter+1. When it reaches TIMEOUT → FAIL, timeout=1, first_bad unchanged (0).
  - start is ignored in CHECK.
- PASS/FAIL: terminal; done=1, pass or fail held.
  - sample_valid is ignored.
  - start=1 → CHECK with all counters cleared, as from IDLE.
- pass and fail are never high together; busy and done are never high together.
- Arithmetic: counters are unsigned.
  - match_count saturates at 2^CNT_W-1, which is unreachable when REQUIRED is legal.
  - The stall counter is ceil(log2(TIMEOUT+1)) bits, internal only.
- No handshake back-pressure: the checker accepts a sample every cycle sample_valid is high.

Test Plan:
- Reset, start pulse, then 8 consecutive valid samples of 4'd12 → pass=1 and done=1 in the cycle after the 8th sample; match_count=8, fail=0, timeout=0.
- start, 3 valid 4'd12, then valid 4'd13 → fail=1 the next cycle; match_count=3, mismatch_count=1, first_bad=4'd13; later samples leave all values unchanged.
- start, 2 valid 4'd12, then sample_valid held low 16 cycles → fail=1 and timeout=1 after the 16th idle cycle; match_count=2.
- Valid 4'd12 interleaved with sample_valid=0 gaps of up to 15 cycles → stall counter clears on each valid sample, no timeout; PASS after 8 matches.
- start coincident with sample_valid=1 (data 4'd12) in IDLE → that sample is not counted (match_count=0 next cycle). A start pulse during CHECK has no effect. start from FAIL clears first_bad and counters and re-enters CHECK.
- RESET_N driven low mid-CHECK, asynchronous to CLK → all outputs 0 immediately; after release, state stays IDLE until start.
